// File: rtl/control_unit.sv
// Multi-cycle control unit: sequences each instruction through FETCH, DECODE,
// EXEC and WB, drives the fetch/register-file/ALU strobes, decodes the
// data-processing operand fields and counts retired instructions.
module control_unit #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      IR,
   input  logic             W_IR_valid,
   output logic             write_ir,
   output logic             write_pc,
   output logic             LA,
   output logic             LB,
   output logic             LC,
   output logic             LF,
   output logic             write_reg,
   output logic             rm_imm_s,
   output logic             rs_imm_s,
   output logic [3:0]       alu_op,
   output logic [1:0]       shift_op,
   output logic [3:0]       rn,
   output logic [3:0]       rd,
   output logic [3:0]       rm,
   output logic [3:0]       rs,
   output logic [4:0]       imm5,
   output logic [7:0]       imm8,
   output logic [3:0]       rot4,
   output logic [CNT_W-1:0] inst_count,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StWb     = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic             cond_ok_q, cond_ok_d;
   logic [CNT_W-1:0] inst_count_q, inst_count_d;

   logic is_dp0, is_dp1, is_dp2, is_dp, is_test_op;

   // Condition field is resolved upstream; it is not needed here.
   logic unused_cond;
   assign unused_cond = ^IR[31:28];

   // Instruction-type decode from the latched IR.
   always_comb begin
      is_dp0     = (IR[27:25] == 3'b000) && !IR[4];
      is_dp1     = (IR[27:25] == 3'b000) && !IR[7] && IR[4];
      is_dp2     = (IR[27:25] == 3'b001);
      is_dp      = is_dp0 || is_dp1 || is_dp2;
      // TST/TEQ/CMP/CMN: always set flags, never write Rd.
      is_test_op = (IR[24:23] == 2'b10);
   end

   // Continuous field slices, valid in every state.
   assign alu_op   = IR[24:21];
   assign shift_op = IR[6:5];
   assign rn       = IR[19:16];
   assign rd       = IR[15:12];
   assign rm       = IR[3:0];
   assign rs       = IR[11:8];
   assign imm5     = IR[11:7];
   assign imm8     = IR[7:0];
   assign rot4     = IR[11:8];
   assign rm_imm_s = is_dp2;
   assign rs_imm_s = is_dp1;

   assign inst_count = inst_count_q;
   assign state      = state_q;

   // Next-state, retired-count and condition-capture logic.
   always_comb begin
      state_d      = state_q;
      inst_count_d = inst_count_q;
      cond_ok_d    = cond_ok_q;
      unique case (state_q)
         StIdle:   state_d = StFetch;
         StFetch:  begin
            state_d   = cond_ok_q ? StDecode : StFetch;
            // Sampled on the same negedge the fetch stage writes IR.
            cond_ok_d = W_IR_valid;
         end
         StDecode: state_d = is_dp ? StExec : StFetch;
         StExec:   state_d = StWb;
         StWb:     begin
            state_d      = StFetch;
            inst_count_d = inst_count_q + CNT_W'(1);
         end
         default:  state_d = StIdle;
      endcase
   end

   // State register and retired-instruction counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         inst_count_q <= '0;
      end else begin
         state_q      <= state_d;
         inst_count_q <= inst_count_d;
      end
   end

   // Condition-pass flag, captured on the negedge only while in FETCH.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         cond_ok_q <= 1'b0;
      end else if (state_q == StFetch) begin
         cond_ok_q <= cond_ok_d;
      end
   end

   // Moore strobes; forced low while reset is held regardless of clock.
   always_comb begin
      write_ir  = 1'b0;
      write_pc  = 1'b0;
      LA        = 1'b0;
      LB        = 1'b0;
      LC        = 1'b0;
      LF        = 1'b0;
      write_reg = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StFetch: begin
               write_ir = 1'b1;
               write_pc = 1'b1;
            end
            StDecode: begin
               LA = is_dp;
               LB = is_dp;
               LC = is_dp;
            end
            StExec:  LF        = IR[20] || is_test_op;
            StWb:    write_reg = !is_test_op;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks ADD, CMP, skipped fetches, a DP1
// register-shift op, an UNDEF, reset mid-EXEC and counter wrap (CNT_W=4).
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IR;
   logic        W_IR_valid;

   logic        write_ir, write_pc, LA, LB, LC, LF, write_reg, rm_imm_s, rs_imm_s;
   logic [3:0]  alu_op, rn, rd, rm, rs, rot4;
   logic [1:0]  shift_op;
   logic [4:0]  imm5;
   logic [7:0]  imm8;
   logic [31:0] inst_count;
   logic [2:0]  state;

   logic        s_write_ir, s_write_pc, s_la, s_lb, s_lc, s_lf, s_write_reg;
   logic        s_rm_imm_s, s_rs_imm_s;
   logic [3:0]  s_alu_op, s_rn, s_rd, s_rm, s_rs, s_rot4;
   logic [1:0]  s_shift_op;
   logic [4:0]  s_imm5;
   logic [7:0]  s_imm8;
   logic [3:0]  s_inst_count;
   logic [2:0]  s_state;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] IrAdd  = 32'hE081_2003;
   localparam logic [31:0] IrCmp  = 32'hE351_0005;
   localparam logic [31:0] IrAdds = 32'hE092_1312;
   localparam logic [31:0] IrLdr  = 32'hE591_2000;

   always #5 clk = ~clk;

   control_unit #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .IR(IR), .W_IR_valid(W_IR_valid),
      .write_ir(write_ir), .write_pc(write_pc), .LA(LA), .LB(LB), .LC(LC), .LF(LF),
      .write_reg(write_reg), .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s),
      .alu_op(alu_op), .shift_op(shift_op), .rn(rn), .rd(rd), .rm(rm), .rs(rs),
      .imm5(imm5), .imm8(imm8), .rot4(rot4), .inst_count(inst_count), .state(state)
   );

   control_unit #(.CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .IR(IR), .W_IR_valid(W_IR_valid),
      .write_ir(s_write_ir), .write_pc(s_write_pc), .LA(s_la), .LB(s_lb), .LC(s_lc),
      .LF(s_lf), .write_reg(s_write_reg), .rm_imm_s(s_rm_imm_s), .rs_imm_s(s_rs_imm_s),
      .alu_op(s_alu_op), .shift_op(s_shift_op), .rn(s_rn), .rd(s_rd), .rm(s_rm),
      .rs(s_rs), .imm5(s_imm5), .imm8(s_imm8), .rot4(s_rot4),
      .inst_count(s_inst_count), .state(s_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one cycle and sample 1 time unit after the posedge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Any strobe high packed into one vector for compact checks.
   function automatic logic [6:0] strobes();
      return {write_ir, write_pc, LA, LB, LC, LF, write_reg};
   endfunction

   initial begin
      rst        = 1'b1;
      IR         = 32'h0;
      W_IR_valid = 1'b0;
      #2;
      check_eq("reset_state", 32'(state), 32'd0);
      check_eq("reset_count", inst_count, 32'd0);
      check_eq("reset_strobes", 32'(strobes()), 32'd0);
      step();
      step();
      check_eq("reset_held_state", 32'(state), 32'd0);
      rst = 1'b0;
      step();
      check_eq("release_fetch", 32'(state), 32'd1);
      check_eq("fetch_strobes", 32'(strobes()), 32'b1100000);

      // ADD r2,r1,r3
      IR = IrAdd; W_IR_valid = 1'b1;
      step();
      check_eq("add_decode_state", 32'(state), 32'd2);
      check_eq("add_decode_strobes", 32'(strobes()), 32'b0011100);
      check_eq("add_rd", 32'(rd), 32'd2);
      check_eq("add_rn", 32'(rn), 32'd1);
      check_eq("add_rm", 32'(rm), 32'd3);
      check_eq("add_rm_imm_s", 32'(rm_imm_s), 32'd0);
      check_eq("add_alu_op", 32'(alu_op), 32'd4);
      step();
      check_eq("add_exec_state", 32'(state), 32'd3);
      check_eq("add_lf", 32'(strobes()), 32'b0000000);
      step();
      check_eq("add_wb_state", 32'(state), 32'd4);
      check_eq("add_write_reg", 32'(strobes()), 32'b0000001);
      step();
      check_eq("add_back_fetch", 32'(state), 32'd1);
      check_eq("add_count", inst_count, 32'd1);

      // CMP r1,#5
      IR = IrCmp;
      step();
      check_eq("cmp_rm_imm_s", 32'(rm_imm_s), 32'd1);
      check_eq("cmp_imm8", 32'(imm8), 32'd5);
      step();
      check_eq("cmp_exec_lf", 32'(strobes()), 32'b0000010);
      step();
      check_eq("cmp_wb_no_write", 32'(strobes()), 32'b0000000);
      check_eq("cmp_wb_state", 32'(state), 32'd4);
      step();
      check_eq("cmp_count", inst_count, 32'd2);

      // Three skipped fetches
      W_IR_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("skip_state", 32'(state), 32'd1);
         check_eq("skip_write_pc", 32'(write_pc), 32'd1);
         check_eq("skip_count", inst_count, 32'd2);
      end

      // ADDS r1,r2,r2,LSL r3 after the skips
      IR = IrAdds; W_IR_valid = 1'b1;
      step();
      check_eq("dp1_decode_state", 32'(state), 32'd2);
      check_eq("dp1_rs_imm_s", 32'(rs_imm_s), 32'd1);
      check_eq("dp1_rm_imm_s", 32'(rm_imm_s), 32'd0);
      check_eq("dp1_shift_op", 32'(shift_op), 32'd0);
      check_eq("dp1_rs", 32'(rs), 32'd3);
      step();
      check_eq("dp1_lf", 32'(LF), 32'd1);
      step();
      check_eq("dp1_write_reg", 32'(write_reg), 32'd1);
      step();
      check_eq("dp1_count", inst_count, 32'd3);

      // LDR is UNDEF: DECODE then straight back to FETCH
      IR = IrLdr;
      step();
      check_eq("undef_decode_state", 32'(state), 32'd2);
      check_eq("undef_no_latch", 32'(strobes()), 32'b0000000);
      step();
      check_eq("undef_back_fetch", 32'(state), 32'd1);
      check_eq("undef_count", inst_count, 32'd3);

      // Reset asserted mid-EXEC
      IR = IrAdds;
      step();
      step();
      check_eq("pre_rst_exec_lf", 32'(LF), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("rst_strobes_drop", 32'(strobes()), 32'd0);
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_count", inst_count, 32'd0);
      step();
      check_eq("rst_no_write_reg", 32'(write_reg), 32'd0);
      step();
      rst = 1'b0;
      step();
      check_eq("rerelease_fetch", 32'(state), 32'd1);

      // Retire 16 ADDs: 4-bit counter wraps to zero
      IR = IrAdd; W_IR_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step(); step(); step(); step();
         if (i == 14) check_eq("small_count_15", 32'(s_inst_count), 32'd15);
      end
      check_eq("wrap_state", 32'(state), 32'd1);
      check_eq("big_count_16", inst_count, 32'd16);
      check_eq("small_count_wrap", 32'(s_inst_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
